// File: rtl/dot_pkg.sv
// dot_pkg: shared FSM encoding and sizing/limit helpers for the dot-product engine.
package dot_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, DONE} dot_state_t;
  typedef struct packed {
    logic signed [63:0] lo;
    logic signed [63:0] hi;
  } lim_t;
  function automatic int dot_steps(int vec_len, int lanes);
    return (vec_len + lanes - 1) / lanes;
  endfunction
  function automatic lim_t sat_limits(int out_w, logic sgn);
    lim_t l;
    l.lo = sgn ? -(64'sd1 <<< (out_w - 1)) : 64'sd0;
    l.hi = sgn ? (64'sd1 <<< (out_w - 1)) - 64'sd1 : (64'sd1 <<< out_w) - 64'sd1;
    return l;
  endfunction
endpackage

// File: rtl/dot_lane_mult.sv
// dot_lane_mult: one registered DATA_W x DATA_W signed/unsigned multiplier lane with clock enable.
module dot_lane_mult #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sgn,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] p
);
  logic signed [DATA_W:0]     ax, bx;
  logic signed [2*DATA_W+1:0] px;
  logic [2*DATA_W-1:0]        p_q, p_d;
  always_comb begin
    ax  = {sgn & a[DATA_W-1], a};
    bx  = {sgn & b[DATA_W-1], b};
    px  = (2*DATA_W+2)'(ax) * (2*DATA_W+2)'(bx);
    p_d = en ? px[2*DATA_W-1:0] : p_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  assign p = p_q;
endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine: multi-lane integer dot product c = sum(a[i]*b[i]) with start/busy/done handshake.
// DOT_SATURATE_EN: when defined, c clamps to the OUT_W range on overflow; otherwise c wraps.
module dot_product_engine
  import dot_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int VEC_LEN = 32,
  parameter int LANES   = 4,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      signed_mode,
  input  logic [VEC_LEN*DATA_W-1:0] a,
  input  logic [VEC_LEN*DATA_W-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [OUT_W-1:0]          c,
  output logic                      ovf
);
  localparam int STEPS = dot_steps(VEC_LEN, LANES);
  localparam int PAD_W = STEPS*LANES*DATA_W;
  localparam int IDX_W = $clog2(STEPS + 1);
  dot_state_t          state_q, state_d;
  logic [PAD_W-1:0]    a_q, a_d, b_q, b_d;
  logic                sm_q, sm_d, pv_q, pv_d, done_q, done_d, ovf_q, ovf_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [OUT_W-1:0]    c_q, c_d, c_n;
  logic                mult_en, ovf_n;
  logic [DATA_W-1:0]   la [LANES];
  logic [DATA_W-1:0]   lb [LANES];
  logic [2*DATA_W-1:0] prod [LANES];
  logic signed [63:0]  acc_x;
  lim_t                lim;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start && !done_q) ? LOAD : IDLE;
      LOAD:    state_d = MAC;
      MAC:     state_d = (idx_q == IDX_W'(STEPS - 1)) ? DRAIN : MAC;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy    = (state_q != IDLE) || done_q;
    mult_en = state_q == MAC;
  end
  // Operands are zero-padded to a whole number of lane groups so the tail group multiplies by zero.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      la[k] = a_q[(int'(idx_q)*LANES + k)*DATA_W +: DATA_W];
      lb[k] = b_q[(int'(idx_q)*LANES + k)*DATA_W +: DATA_W];
    end
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dot_lane_mult #(.DATA_W(DATA_W)) u_mult (
      .clk(clk), .rst_n(rst_n), .en(mult_en), .sgn(sm_q),
      .a(la[k]), .b(lb[k]), .p(prod[k])
    );
  end
  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++)
      sum = sum + (sm_q ? ACC_W'($signed(prod[k])) : ACC_W'(prod[k]));
  end
  always_comb begin
    a_d    = state_q == LOAD ? PAD_W'(a) : a_q;
    b_d    = state_q == LOAD ? PAD_W'(b) : b_q;
    sm_d   = state_q == LOAD ? signed_mode : sm_q;
    idx_d  = state_q == LOAD ? '0 : (mult_en && idx_q != IDX_W'(STEPS - 1)) ? idx_q + 1'b1 : idx_q;
    pv_d   = mult_en;
    acc_d  = state_q == LOAD ? '0 : pv_q ? acc_q + sum : acc_q;
    acc_x  = sm_q ? 64'($signed(acc_q)) : 64'(acc_q);
    lim    = sat_limits(OUT_W, sm_q);
    ovf_n  = (acc_x < $signed(lim.lo)) || (acc_x > $signed(lim.hi));
`ifdef DOT_SATURATE_EN
    c_n    = ovf_n ? ((acc_x < $signed(lim.lo)) ? lim.lo[OUT_W-1:0] : lim.hi[OUT_W-1:0]) : acc_q[OUT_W-1:0];
`else
    c_n    = acc_q[OUT_W-1:0];
`endif
    ovf_d  = state_q == DONE ? ovf_n : ovf_q;
    c_d    = state_q == DONE ? c_n : c_q;
    done_d = state_q == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sm_q   <= 1'b0;
      idx_q  <= '0;
      pv_q   <= 1'b0;
      acc_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sm_q   <= sm_d;
      idx_q  <= idx_d;
      pv_q   <= pv_d;
      acc_q  <= acc_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  assign done = done_q;
  assign c    = c_q;
  assign ovf  = ovf_q;
endmodule
